// File: rtl/reg_wb_arbiter_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
package reg_wb_arbiter_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned NREG   = 2 ** ADDR_W;

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_MEM = 1'b1
  } gnt_e;

  typedef struct packed {
    logic [ADDR_W-1:0] id;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/reg_wb_arbiter_rr_arb2.sv
// Two-requester round-robin arbiter; remembers the last winner so ties alternate.
module rr_arb2
  import reg_wb_arbiter_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic req_alu_i,
  input  logic req_mem_i,
  output logic gnt_alu_c_o,
  output logic gnt_mem_c_o
);

  gnt_e last_q;
  gnt_e last_d;

  // Last-grant register; MEM after reset so the ALU wins the first tie.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= GNT_MEM;
    end else begin
      last_q <= last_d;
    end
  end

  // Grant: a lone requester wins, a tie goes to whoever did not win last.
  always_comb begin
    gnt_alu_c_o = 1'b0;
    gnt_mem_c_o = 1'b0;
    if (en_i) begin
      if (req_alu_i && (!req_mem_i || (last_q == GNT_MEM))) begin
        gnt_alu_c_o = 1'b1;
      end else if (req_mem_i) begin
        gnt_mem_c_o = 1'b1;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (gnt_alu_c_o) begin
      last_d = GNT_ALU;
    end else if (gnt_mem_c_o) begin
      last_d = GNT_MEM;
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Write-back arbiter for the 8x16 register file: ALU/MEM round-robin onto the
// single write port, plus a busy scoreboard for RAW hazards and WAW claims.
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              ALU_Valid,
  output logic              ALU_Ready,
  input  logic [ADDR_W-1:0] ALU_W_ID,
  input  logic [DATA_W-1:0] ALU_WData,
  input  logic              MEM_Valid,
  output logic              MEM_Ready,
  input  logic [ADDR_W-1:0] MEM_W_ID,
  input  logic [DATA_W-1:0] MEM_WData,
  input  logic              Claim_Valid,
  output logic              Claim_Ready,
  input  logic [ADDR_W-1:0] Claim_ID,
  input  logic [ADDR_W-1:0] RS_ID,
  input  logic [ADDR_W-1:0] RT_ID,
  output logic              Hazard,
  output logic [NREG-1:0]   Busy_Mask,
  output logic              Reg_Write,
  output logic [ADDR_W-1:0] Reg_W_ID,
  output logic [DATA_W-1:0] Reg_WData
);

  logic            live_q;
  logic            en;
  logic            gnt_alu;
  logic            gnt_mem;
  logic            xfer;
  logic            claim_ok;
  logic            wr_q,   wr_d;
  wb_req_t         wb_q,   wb_d;
  logic [NREG-1:0] busy_q, busy_d;

  // Handshakes stay closed while in reset and for the first edge after release.
  assign en = RST_N & live_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      live_q <= 1'b0;
    end else begin
      live_q <= 1'b1;
    end
  end

  rr_arb2 u_arb (
    .clk_i       (CLK),
    .rst_ni      (RST_N),
    .en_i        (en),
    .req_alu_i   (ALU_Valid),
    .req_mem_i   (MEM_Valid),
    .gnt_alu_c_o (gnt_alu),
    .gnt_mem_c_o (gnt_mem)
  );

  assign xfer     = gnt_alu | gnt_mem;
  assign claim_ok = en & Claim_Valid & ~busy_q[Claim_ID];

  // Write-port capture: winner's ID/data load on transfer, otherwise hold.
  always_comb begin
    wr_d = xfer;
    wb_d = wb_q;
    if (gnt_alu) begin
      wb_d = '{id: ALU_W_ID, data: ALU_WData};
    end else if (gnt_mem) begin
      wb_d = '{id: MEM_W_ID, data: MEM_WData};
    end
  end

  // Scoreboard: clear on write first, then a same-edge claim re-sets the bit.
  always_comb begin
    busy_d = busy_q;
    if (xfer) begin
      busy_d[wb_d.id] = 1'b0;
    end
    if (claim_ok) begin
      busy_d[Claim_ID] = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_q   <= 1'b0;
      wb_q   <= '0;
      busy_q <= '0;
    end else begin
      wr_q   <= wr_d;
      wb_q   <= wb_d;
      busy_q <= busy_d;
    end
  end

  assign ALU_Ready   = gnt_alu;
  assign MEM_Ready   = gnt_mem;
  assign Claim_Ready = claim_ok;
  assign Hazard      = busy_q[RS_ID] | busy_q[RT_ID];
  assign Busy_Mask   = busy_q;
  assign Reg_Write   = wr_q;
  assign Reg_W_ID    = wb_q.id;
  assign Reg_WData   = wb_q.data;

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Write-back arbiter and scoreboard for the 8 x 16-bit register file.
- Two producers share the file's single write port: ALU writeback and MEM (load) writeback.
- Arbitration is round-robin with a valid/ready handshake. Selected writes are registered onto Reg_Write / Reg_W_ID / Reg_WData.
- A per-register busy scoreboard gives decode a RAW hazard stall and a WAW claim handshake.

Parameters:
- DATA_W, 16, register data width.
- ADDR_W, 3, register index width.
- NREG, 8, number of registers (2**ADDR_W).

Ports:
- CLK  input  1  clock; all state updates on posedge.
- RST_N  input  1  asynchronous active-low reset.
- ALU_Valid  input  1  ALU write request.
- ALU_Ready  output  1  ALU request accepted this cycle.
- ALU_W_ID  input  ADDR_W  ALU destination register.
- ALU_WData  input  DATA_W  ALU write data.
- MEM_Valid  input  1  MEM write request.
- MEM_Ready  output  1  MEM request accepted this cycle.
- MEM_W_ID  input  ADDR_W  MEM destination register.
- MEM_WData  input  DATA_W  MEM write data.
- Claim_Valid  input  1  decode reserves a destination register.
- Claim_Ready  output  1  reservation accepted.
- Claim_ID  input  ADDR_W  register being reserved.
- RS_ID  input  ADDR_W  decode source operand 1.
- RT_ID  input  ADDR_W  decode source operand 2.
- Hazard  output  1  a source operand is busy.
- Busy_Mask  output  NREG  scoreboard state.
- Reg_Write  output  1  register-file write enable.
- Reg_W_ID  output  ADDR_W  register-file write index.
- Reg_WData  output  DATA_W  register-file write data.

Behaviour:
- Reset (async, RST_N low):
  - Reg_Write=0, Reg_W_ID=0, Reg_WData=0, Busy_Mask=0.
  - Last_Grant=MEM, so the ALU wins the first tie.
  - ALU_Ready, MEM_Ready and Claim_Ready are forced 0 while RST_N is low.
  - Reset mid-transfer discards any pending write. No write is issued on the first edge after release.
- Arbitration (combinational grant):
  - Only ALU_Valid: ALU_Ready=1.
  - Only MEM_Valid: MEM_Ready=1.
  - Both valid: grant the requester that is not Last_Grant; the other Ready=0.
  - Neither valid: both Ready=0.
  - Ready never asserts without the matching Valid. At most one Ready is high per cycle.
- Transfer = Valid && Ready.
  - On that posedge, Last_Grant updates to the winner.
  - Reg_W_ID / Reg_WData capture the winner's ID and data; Reg_Write=1.
  - With no transfer, Reg_Write=0 and Reg_W_ID / Reg_WData hold.
  - Latency: accept at edge N, write presented from N through N+1, committed by the register file on the intervening negedge.
- Requesters must hold Valid, ID and Data stable until Ready. A loser keeps requesting and is granted the next cycle.
- Scoreboard:
  - Claim_Ready = Claim_Valid && !Busy_Mask[Claim_ID] (WAW stall).
  - An accepted claim sets Busy_Mask[Claim_ID] at posedge.
  - An accepted write clears Busy_Mask[winner W_ID] at the same posedge it is captured.
  - Simultaneous clear and set of the same ID: the clear applies first and the set wins, so the bit ends 1.
  - A write to a non-busy register is legal and leaves the bit 0.
- Hazard = Busy_Mask[RS_ID] | Busy_Mask[RT_ID], combinational from registered state.
- Register 0 has no special treatment.

Decomposition:
- Shared package: DATA_W, ADDR_W, NREG constants; grant encoding GNT_ALU=0, GNT_MEM=1.
- Sub-module rr_arb2: 2-requester round-robin arbiter holding the Last_Grant flop. Top level holds the write-port register and the scoreboard.

Test Plan:
- Reset release, idle 3 cycles -> Reg_Write=0, Busy_Mask=8'h00, Hazard=0, both Ready=0.
- ALU_Valid=1, ALU_W_ID=3, ALU_WData=16'h1234 for one cycle -> ALU_Ready=1 same cycle; next cycle Reg_Write=1, Reg_W_ID=3, Reg_WData=16'h1234; following cycle Reg_Write=0.
- ALU (id 1, 16'hAAAA) and MEM (id 2, 16'h5555) valid together for 2 cycles -> ALU granted first, then MEM. Reg writes appear in order id1 then id2 on consecutive cycles.
- Claim_ID=5 accepted; next cycle Claim_ID=5 again -> Claim_Ready=0; RS_ID=5 -> Hazard=1. MEM writes id 5 -> Busy_Mask[5]=0 next cycle, Hazard=0, a new claim of 5 is accepted.
- Same-edge ALU write to id 4 (busy) and claim of id 4 -> Busy_Mask[4]=1 afterward.
- Assert RST_N=0 mid-cycle with ALU_Valid=1 and Busy_Mask=8'h30 -> outputs clear immediately, no Reg_Write after release.
